// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage_pkg
//  Description : Shared encodings and access-classification helpers for the
//                memory-access / write-back stage.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_wb_stage_pkg;

    localparam int MEM_OP_BUS = 4;
    localparam int BYTE_SEL_W = 4;
    localparam int DATA_W     = 32;
    localparam int GPR_ADDR_W = 5;

    localparam logic [MEM_OP_BUS-1:0] MEM_OP_NONE = 4'd0;
    localparam logic [MEM_OP_BUS-1:0] MEM_OP_LB   = 4'd1;
    localparam logic [MEM_OP_BUS-1:0] MEM_OP_LBU  = 4'd2;
    localparam logic [MEM_OP_BUS-1:0] MEM_OP_LH   = 4'd3;
    localparam logic [MEM_OP_BUS-1:0] MEM_OP_LHU  = 4'd4;
    localparam logic [MEM_OP_BUS-1:0] MEM_OP_LW   = 4'd5;
    localparam logic [MEM_OP_BUS-1:0] MEM_OP_SB   = 4'd6;
    localparam logic [MEM_OP_BUS-1:0] MEM_OP_SH   = 4'd7;
    localparam logic [MEM_OP_BUS-1:0] MEM_OP_SW   = 4'd8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } state_e;

    function automatic logic is_load(input logic [MEM_OP_BUS-1:0] op);
        return (op >= MEM_OP_LB) && (op <= MEM_OP_LW);
    endfunction

    function automatic logic is_store(input logic [MEM_OP_BUS-1:0] op);
        return (op >= MEM_OP_SB) && (op <= MEM_OP_SW);
    endfunction

    function automatic logic is_misaligned(input logic [MEM_OP_BUS-1:0] op,
                                           input logic [1:0]            offset);
        logic r;
        case (op)
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: r = offset[0];
            MEM_OP_LW, MEM_OP_SW:             r = |offset;
            default:                          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : mem_load_align
//  Description : Big-endian lane logic: load byte/halfword select with
//                sign/zero extension, store lane replication and byte enables.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_load_align
    import mem_wb_stage_pkg::*;
(
    input  logic [MEM_OP_BUS-1:0] access_op_i,
    input  logic [1:0]            access_offset_i,
    input  logic [DATA_W-1:0]     store_data_i,
    output logic [BYTE_SEL_W-1:0] byte_sel_o,
    output logic [DATA_W-1:0]     wdata_o,
    input  logic [MEM_OP_BUS-1:0] load_op_i,
    input  logic [1:0]            load_offset_i,
    input  logic [DATA_W-1:0]     rdata_i,
    output logic [DATA_W-1:0]     load_data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Offset 0 is the most significant lane.
    always_comb begin
        case (load_offset_i)
            2'd0:    w_byte = rdata_i[31:24];
            2'd1:    w_byte = rdata_i[23:16];
            2'd2:    w_byte = rdata_i[15:8];
            default: w_byte = rdata_i[7:0];
        endcase
        w_half = load_offset_i[1] ? rdata_i[15:0] : rdata_i[31:16];
    end

    always_comb begin
        case (load_op_i)
            MEM_OP_LB:  load_data_o = {{24{w_byte[7]}}, w_byte};
            MEM_OP_LBU: load_data_o = {24'd0, w_byte};
            MEM_OP_LH:  load_data_o = {{16{w_half[15]}}, w_half};
            MEM_OP_LHU: load_data_o = {16'd0, w_half};
            MEM_OP_LW:  load_data_o = rdata_i;
            default:    load_data_o = '0;
        endcase
    end

    always_comb begin
        case (access_op_i)
            MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: begin
                case (access_offset_i)
                    2'd0:    byte_sel_o = 4'b1000;
                    2'd1:    byte_sel_o = 4'b0100;
                    2'd2:    byte_sel_o = 4'b0010;
                    default: byte_sel_o = 4'b0001;
                endcase
            end
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH:
                byte_sel_o = access_offset_i[1] ? 4'b0011 : 4'b1100;
            MEM_OP_LW, MEM_OP_SW:
                byte_sel_o = 4'b1111;
            default:
                byte_sel_o = 4'b0000;
        endcase
    end

    always_comb begin
        case (access_op_i)
            MEM_OP_SB: wdata_o = {4{store_data_i[7:0]}};
            MEM_OP_SH: wdata_o = {2{store_data_i[15:0]}};
            MEM_OP_SW: wdata_o = store_data_i;
            default:   wdata_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage
//  Description : Memory-access and write-back stage with a single-outstanding
//                request/ready data bus transaction and timeout abort.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TIMER_WIDTH    = 5
)
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  in_write_enable,
    input  logic [GPR_ADDR_W-1:0] in_write_addr,
    input  logic [DATA_W-1:0]     in_write_data,
    input  logic [MEM_OP_BUS-1:0] in_mem_op,
    input  logic [DATA_W-1:0]     in_mem_addr,
    input  logic [DATA_W-1:0]     in_store_data,
    input  logic                  flush,
    output logic                  stall_request,
    output logic                  bus_request,
    output logic                  bus_write,
    output logic [DATA_W-1:0]     bus_addr,
    output logic [BYTE_SEL_W-1:0] bus_byte_sel,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_ready,
    input  logic [DATA_W-1:0]     bus_rdata,
    output logic                  wb_write_enable,
    output logic [GPR_ADDR_W-1:0] wb_write_addr,
    output logic [DATA_W-1:0]     wb_write_data,
    output logic                  align_error,
    output logic                  bus_error
);

    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [TIMER_WIDTH-1:0]  timer_q, timer_d;
    logic                    flush_seen_q, flush_seen_d;
    logic [MEM_OP_BUS-1:0]   op_q, op_d;
    logic [1:0]              offset_q, offset_d;
    logic                    we_q, we_d;
    logic [GPR_ADDR_W-1:0]   dest_q, dest_d;

    logic                    bus_request_q, bus_request_d;
    logic                    bus_write_q, bus_write_d;
    logic [DATA_W-1:0]       bus_addr_q, bus_addr_d;
    logic [BYTE_SEL_W-1:0]   bus_byte_sel_q, bus_byte_sel_d;
    logic [DATA_W-1:0]       bus_wdata_q, bus_wdata_d;
    logic                    wb_we_q, wb_we_d;
    logic [GPR_ADDR_W-1:0]   wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]       wb_data_q, wb_data_d;
    logic                    align_error_q, align_error_d;
    logic                    bus_error_q, bus_error_d;

    logic [BYTE_SEL_W-1:0]   w_byte_sel;
    logic [DATA_W-1:0]       w_wdata;
    logic [DATA_W-1:0]       w_load_data;
    logic                    w_is_mem;
    logic                    w_timeout;

    mem_load_align u_align (
        .access_op_i     (in_mem_op),
        .access_offset_i (in_mem_addr[1:0]),
        .store_data_i    (in_store_data),
        .byte_sel_o      (w_byte_sel),
        .wdata_o         (w_wdata),
        .load_op_i       (op_q),
        .load_offset_i   (offset_q),
        .rdata_i         (bus_rdata),
        .load_data_o     (w_load_data)
    );

    assign w_is_mem  = is_load(in_mem_op) || is_store(in_mem_op);
    assign w_timeout = (state_q == ST_BUS) && !bus_ready && (timer_q == TIMER_LAST);

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        flush_seen_d   = flush_seen_q;
        op_d           = op_q;
        offset_d       = offset_q;
        we_d           = we_q;
        dest_d         = dest_q;
        bus_request_d  = bus_request_q;
        bus_write_d    = bus_write_q;
        bus_addr_d     = bus_addr_q;
        bus_byte_sel_d = bus_byte_sel_q;
        bus_wdata_d    = bus_wdata_q;
        wb_we_d        = 1'b0;
        wb_addr_d      = wb_addr_q;
        wb_data_d      = wb_data_q;
        align_error_d  = 1'b0;
        bus_error_d    = 1'b0;
        stall_request  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (!w_is_mem || flush) begin
                        wb_we_d   = in_write_enable & ~flush;
                        wb_addr_d = in_write_addr;
                        wb_data_d = in_write_data;
                    end else if (is_misaligned(in_mem_op, in_mem_addr[1:0])) begin
                        align_error_d = 1'b1;
                    end else begin
                        stall_request  = 1'b1;
                        state_d        = ST_BUS;
                        timer_d        = '0;
                        flush_seen_d   = 1'b0;
                        op_d           = in_mem_op;
                        offset_d       = in_mem_addr[1:0];
                        we_d           = in_write_enable;
                        dest_d         = in_write_addr;
                        bus_request_d  = 1'b1;
                        bus_write_d    = is_store(in_mem_op);
                        bus_addr_d     = {in_mem_addr[DATA_W-1:2], 2'b00};
                        bus_byte_sel_d = w_byte_sel;
                        bus_wdata_d    = w_wdata;
                    end
                end
            end
            ST_BUS: begin
                // A flush never aborts the handshake; it only kills the write-back.
                flush_seen_d  = flush_seen_q | flush;
                stall_request = ~bus_ready & ~w_timeout;
                if (bus_ready) begin
                    state_d       = ST_IDLE;
                    bus_request_d = 1'b0;
                    if (is_load(op_q)) begin
                        wb_we_d   = we_q & ~(flush_seen_q | flush);
                        wb_addr_d = dest_q;
                        wb_data_d = w_load_data;
                    end
                end else if (w_timeout) begin
                    state_d       = ST_IDLE;
                    bus_request_d = 1'b0;
                    bus_error_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_WIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            timer_q        <= '0;
            flush_seen_q   <= 1'b0;
            op_q           <= MEM_OP_NONE;
            offset_q       <= 2'd0;
            we_q           <= 1'b0;
            dest_q         <= '0;
            bus_request_q  <= 1'b0;
            bus_write_q    <= 1'b0;
            bus_addr_q     <= '0;
            bus_byte_sel_q <= '0;
            bus_wdata_q    <= '0;
            wb_we_q        <= 1'b0;
            wb_addr_q      <= '0;
            wb_data_q      <= '0;
            align_error_q  <= 1'b0;
            bus_error_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            flush_seen_q   <= flush_seen_d;
            op_q           <= op_d;
            offset_q       <= offset_d;
            we_q           <= we_d;
            dest_q         <= dest_d;
            bus_request_q  <= bus_request_d;
            bus_write_q    <= bus_write_d;
            bus_addr_q     <= bus_addr_d;
            bus_byte_sel_q <= bus_byte_sel_d;
            bus_wdata_q    <= bus_wdata_d;
            wb_we_q        <= wb_we_d;
            wb_addr_q      <= wb_addr_d;
            wb_data_q      <= wb_data_d;
            align_error_q  <= align_error_d;
            bus_error_q    <= bus_error_d;
        end
    end

    assign bus_request     = bus_request_q;
    assign bus_write       = bus_write_q;
    assign bus_addr        = bus_addr_q;
    assign bus_byte_sel    = bus_byte_sel_q;
    assign bus_wdata       = bus_wdata_q;
    assign wb_write_enable = wb_we_q;
    assign wb_write_addr   = wb_addr_q;
    assign wb_write_data   = wb_data_q;
    assign align_error     = align_error_q;
    assign bus_error       = bus_error_q;

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access and write-back stage. Consumes the EX/MEM result and drives the GPR file write port (write_enable/write_addr/write_data).
- Non-memory results pass through with one registered cycle.
- Loads and stores run a single-outstanding request/ready transaction on the data bus, with a timeout. Loads are aligned and extended before write-back.
- Raises a pipeline stall while an access is pending.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles in BUS state waiting for bus_ready before abort (must be >=1).
- TIMER_WIDTH, 5: width of timeout counter (must hold TIMEOUT_CYCLES).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX/MEM slot holds an instruction.
- in_write_enable  in  1  instruction writes a GPR.
- in_write_addr  in  5  destination GPR.
- in_write_data  in  32  ALU result (non-memory ops).
- in_mem_op  in  4  NONE=0 LB=1 LBU=2 LH=3 LHU=4 LW=5 SB=6 SH=7 SW=8; other codes act as NONE.
- in_mem_addr  in  32  effective byte address.
- in_store_data  in  32  store source register value.
- flush  in  1  discard the current/pending instruction's write-back.
- stall_request  out  1  hold upstream stages; inputs stay stable while high.
- bus_request  out  1  data bus request (registered).
- bus_write  out  1  1=store, 0=load (registered).
- bus_addr  out  32  word address {addr[31:2],2'b00} (registered).
- bus_byte_sel  out  4  byte-lane enables (registered).
- bus_wdata  out  32  store data replicated to lanes (registered).
- bus_ready  in  1  transaction complete this cycle.
- bus_rdata  in  32  load data, valid with bus_ready.
- wb_write_enable  out  1  to GPR file.
- wb_write_addr  out  5  to GPR file.
- wb_write_data  out  32  to GPR file.
- align_error  out  1  one-cycle pulse: misaligned access dropped.
- bus_error  out  1  one-cycle pulse: timeout abort.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, timer=0, all registered outputs 0.
- Endianness: big-endian. Byte offset 0 = bits 31:24 = bus_byte_sel[3].
- Misalignment:
  - Halfword: addr[0]!=0.
  - Word: addr[1:0]!=0.
- IDLE:
  - Case A, in_valid and (NONE, or flush): next cycle wb_* = in_write_enable&~flush, in_write_addr, in_write_data. Stays IDLE.
  - Case B, in_valid, memory op, misaligned, no flush: next cycle align_error=1, wb_write_enable=0, no bus activity. Stays IDLE.
  - Case C, in_valid, memory op, aligned, no flush: stall_request=1 combinationally. Next cycle state=BUS, bus_request=1, bus signals latched, timer=0, wb_write_enable=0.
  - in_valid=0: wb_write_enable=0 next cycle.
- BUS:
  - stall_request = ~bus_ready.
  - Timer increments each cycle without bus_ready.
  - On bus_ready:
    - bus_request drops next cycle; state returns to IDLE.
    - Load: wb_write_enable=in_write_enable&~flush_seen, data aligned/extended.
    - Store: wb_write_enable=0.
  - Timeout (timer==TIMEOUT_CYCLES-1 without ready): bus_request drops, bus_error pulses, no write-back, stall_request=0 that cycle, state returns to IDLE.
- Lane data:
  - LB/LBU: selected byte sign/zero-extended.
  - LH/LHU: halfword at offset 0 or 2, extended.
  - LW: full word.
  - Stores: SB replicates byte x4, SH replicates halfword x2. byte_sel is 1000>>offset (byte) or 1100/0011 (halfword) or 1111 (word).
- Flush while in BUS: handshake still completes (no mid-transaction abort); flush_seen latched, write-back suppressed.
- bus_ready while IDLE is ignored.
- Latency:
  - Non-memory: 1 cycle.
  - Memory: write-back 2+N cycles after acceptance, where N = wait cycles before bus_ready.
- wb_write_addr 0 is passed through unfiltered; the GPR file discards it.

Decomposition:
- Shared macro header: MEM_OP_* encodings, MEM_OP_BUS width, state encodings, BYTE_SEL widths.
- Sub-module mem_load_align: combinational lane select plus sign/zero extension for loads, and store lane replication/byte_sel generation.
- FSM, timer and output registers stay in mem_wb_stage.

Test Plan:
- NONE, write_enable=1, addr=5, data=0xDEADBEEF -> next cycle wb_write_enable=1, addr 5, data 0xDEADBEEF; stall_request=0 throughout.
- LB addr 0x1003, bus_rdata=0x112233F0, ready after 2 waits -> bus_addr 0x1000, byte_sel 0001; wb_write_data=0xFFFFFFF0 4 cycles after accept; stall high 3 cycles.
- LHU addr 0x2002, rdata=0xAAAA8001, ready immediately -> wb_write_data=0x00008001; SH addr 0x2002 data 0x1234 -> byte_sel 0011, bus_wdata 0x12341234, wb_write_enable=0.
- LW addr 0x3001 -> align_error pulse next cycle, bus_request never asserts, wb_write_enable=0.
- LW with bus_ready never asserted, TIMEOUT_CYCLES=16 -> bus_error pulses after 16 BUS cycles, stall releases, no write-back.
- Flush during BUS wait, then bus_ready -> no write-back. Reset driven low mid-BUS -> bus_request and wb_* go 0 immediately; state IDLE after release.
